// File: rtl/seq1010_tx_if.sv
// Parallel word handshake into the 1010 frame transmitter.
interface seq1010_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq1010_tx.sv
// Serial frame transmitter: 1010 preamble, data MSB-first, optional even parity,
// then a fixed zero gap so a downstream 1010 detector can find frame starts.
module seq1010_tx #(
  parameter int               DATA_W    = 8,
  parameter int               PRE_W     = 4,
  parameter logic [PRE_W-1:0] PREAMBLE  = 4'b1010,
  parameter bit               PARITY_EN = 1'b1,
  parameter int               GAP_CYC   = 2
) (
  input  logic         clk,
  input  logic         reset,
  seq1010_tx_if.slave  link,
  output logic         out,
  output logic         out_valid,
  output logic         busy,
  output logic         done
);

  localparam int FRAME_W = PRE_W + DATA_W + (PARITY_EN ? 1 : 0);
  localparam int CNT_W   = $clog2(FRAME_W + GAP_CYC);
  localparam int SR_W    = PRE_W + DATA_W;

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [SR_W-1:0]   sr, sr_nx;
  logic              par, par_nx;
  logic              ready, ready_nx;
  logic              out_nx, out_valid_nx, busy_nx, done_nx;
  logic              accept;

  assign link.in_ready = ready;
  assign accept        = link.in_valid & ready;

  // Outputs are registered from the next-state view, so frame bit 0 appears
  // on the accept edge itself; the preamble rides in the shift register
  // ahead of the data so both leave through the same MSB tap.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    sr_nx        = sr;
    par_nx       = par;
    ready_nx     = 1'b0;
    out_nx       = 1'b0;
    out_valid_nx = 1'b0;
    busy_nx      = 1'b1;
    done_nx      = 1'b0;
    unique case (state)
      IDLE: begin
        busy_nx  = 1'b0;
        ready_nx = 1'b1;
        if (accept) begin
          state_nx     = PRE;
          cnt_nx       = '0;
          sr_nx        = {PREAMBLE, link.in_data} << 1;
          par_nx       = ^link.in_data;
          out_nx       = PREAMBLE[PRE_W-1];
          out_valid_nx = 1'b1;
          busy_nx      = 1'b1;
          ready_nx     = 1'b0;
        end
      end
      PRE: begin
        out_nx       = sr[SR_W-1];
        out_valid_nx = 1'b1;
        sr_nx        = sr << 1;
        if (cnt == CNT_W'(PRE_W - 1)) begin
          state_nx = DATA;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt != CNT_W'(DATA_W - 1)) begin
          out_nx       = sr[SR_W-1];
          out_valid_nx = 1'b1;
          sr_nx        = sr << 1;
          cnt_nx       = cnt + 1'b1;
        end else if (PARITY_EN) begin
          state_nx     = PAR;
          cnt_nx       = '0;
          out_nx       = par;
          out_valid_nx = 1'b1;
        end else begin
          state_nx = GAP;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end
      end
      PAR: begin
        state_nx = GAP;
        cnt_nx   = '0;
        done_nx  = 1'b1;
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          busy_nx  = 1'b0;
          ready_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      par       <= 1'b0;
      ready     <= 1'b0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      par       <= par_nx;
      ready     <= ready_nx;
      out       <= out_nx;
      out_valid <= out_valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule
